// File: rtl/sprite_loader.sv
// Streams a host byte sequence (SYNC, select, pixels) into one of two sprite
// atlases, emitting one registered VRAM write per accepted pixel byte.
module sprite_loader #(
  parameter int          COLS = 126,
  parameter int          ROWS = 96,
  parameter logic [7:0]  SYNC = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        abort,
  output logic        wr_en,
  output logic [13:0] wr_addr,
  output logic [2:0]  wr_data,
  output logic        wr_select,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, SEL, LOAD, DONE} state_t;

  localparam logic [6:0] COL_LAST = 7'(COLS - 1);
  localparam logic [6:0] ROW_LAST = 7'(ROWS - 1);

  state_t      state_q, state_d;
  logic [6:0]  row_q, row_d, col_q, col_d;
  logic        wr_en_q, wr_en_d;
  logic [13:0] wr_addr_q, wr_addr_d;
  logic [2:0]  wr_data_q, wr_data_d;
  logic        wr_select_q, wr_select_d;
  logic        err_q, err_d;
  logic        xfer;

  assign in_ready  = (state_q != DONE);
  assign busy      = (state_q == SEL) || (state_q == LOAD);
  assign done      = (state_q == DONE);
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign wr_select = wr_select_q;
  assign err       = err_q;
  assign xfer      = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_select_d = wr_select_q;
    err_d       = 1'b0;
    if (abort) begin
      // Cancel wins over everything, including a byte on the same cycle.
      state_d = IDLE;
      row_d   = '0;
      col_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: if (xfer && in_data == SYNC) state_d = SEL;
        SEL: if (xfer) begin
          if (in_data == 8'h00 || in_data == 8'h01) begin
            wr_select_d = in_data[0];
            row_d       = '0;
            col_d       = '0;
            state_d     = LOAD;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
        LOAD: if (xfer) begin
          wr_en_d   = 1'b1;
          wr_addr_d = {row_q, col_q};
          wr_data_d = in_data[2:0];
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              row_d   = '0;
              state_d = DONE;
            end else begin
              row_d = row_q + 7'd1;
            end
          end else begin
            col_d = col_q + 7'd1;
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_select_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_select_q <= wr_select_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_sprite_loader.sv
// Directed + randomized bench for sprite_loader; expected outputs come from a
// byte-stream model that tracks a linear pixel index per atlas.
module tb_sprite_loader;
  localparam int COLS = 126;
  localparam int ROWS = 96;
  localparam int NPIX = COLS * ROWS;
  localparam logic [7:0] SYNC = 8'hA5;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        abort;
  logic        wr_en;
  logic [13:0] wr_addr;
  logic [2:0]  wr_data;
  logic        wr_select;
  logic        busy;
  logic        done;
  logic        err;

  sprite_loader #(.COLS(COLS), .ROWS(ROWS), .SYNC(SYNC)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .abort(abort), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_select(wr_select), .busy(busy), .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model: phase 0=waiting for sync, 1=expect select, 2=pixels, 3=finished
  int          m_phase = 0;
  int          m_idx   = 0;
  logic        e_en = 0, e_sel = 0, e_done = 0, e_err = 0;
  logic [13:0] e_addr = 0;
  logic [2:0]  e_data = 0;

  int          n_wr, n_done, n_err;
  logic [13:0] first_addr, last_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    n_wr = 0; n_done = 0; n_err = 0; first_addr = '1; last_addr = '0;
  endtask

  task automatic cyc(input logic [7:0] d, input logic v, input logic ab, input logic rs);
    logic rdy;
    in_data = d; in_valid = v; abort = ab; reset = rs;
    rdy = (m_phase != 3);
    e_en = 0; e_done = 0; e_err = 0;
    if (!rs) begin
      m_phase = 0; m_idx = 0; e_addr = 0; e_data = 0; e_sel = 0;
    end else if (ab) begin
      m_phase = 0; m_idx = 0;
    end else begin
      case (m_phase)
        0: if (v && d == SYNC) m_phase = 1;
        1: if (v) begin
          if (d == 8'h00 || d == 8'h01) begin
            e_sel = d[0]; m_idx = 0; m_phase = 2;
          end else begin
            e_err = 1; m_phase = 0;
          end
        end
        2: if (v) begin
          e_en   = 1;
          e_addr = 14'(((m_idx / COLS) << 7) | (m_idx % COLS));
          e_data = d[2:0];
          m_idx++;
          if (m_idx == NPIX) begin m_phase = 3; m_idx = 0; end
        end
        default: m_phase = 0;
      endcase
      e_done = (m_phase == 3);
    end
    if (!rdy && rs) begin end
    @(posedge clk); #1;
    chk("wr_en", wr_en, e_en);
    chk("wr_addr", wr_addr, e_addr);
    chk("wr_data", wr_data, e_data);
    chk("wr_select", wr_select, e_sel);
    chk("done", done, e_done);
    chk("err", err, e_err);
    chk("busy", busy, (m_phase == 1 || m_phase == 2));
    chk("in_ready", in_ready, (m_phase != 3));
    if (wr_en) begin
      n_wr++;
      if (first_addr == '1) first_addr = wr_addr;
      last_addr = wr_addr;
    end
    if (done) n_done++;
    if (err) n_err++;
  endtask

  task automatic send(input logic [7:0] d);
    cyc(d, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic idle_cyc();
    cyc($urandom, 1'b0, 1'b0, 1'b1);
  endtask

  logic [13:0] addr_after_row0;

  initial begin
    reset = 0; in_data = 0; in_valid = 0; abort = 0;
    // reset state
    cyc(8'h00, 1'b0, 1'b0, 1'b0);
    cyc(8'hA5, 1'b1, 1'b0, 1'b0);
    idle_cyc();

    // full atlas 0 load, data = index mod 8
    clr_stats();
    addr_after_row0 = '0;
    send(SYNC); send(8'h00);
    for (int i = 0; i < NPIX; i++) begin
      send(8'(i % 8));
      if (i == COLS) addr_after_row0 = wr_addr;
    end
    idle_cyc(); idle_cyc();
    chk("full_writes", n_wr, NPIX);
    chk("full_first", first_addr, 14'h0000);
    chk("full_row1", addr_after_row0, 14'h0080);
    chk("full_last", last_addr, 14'h2FFD);
    chk("full_done", n_done, 1);
    chk("full_sel", wr_select, 1'b0);

    // junk byte dropped, atlas 1 single pixel
    clr_stats();
    send(8'h3C); send(SYNC); send(8'h01); send(8'h07);
    chk("a1_writes", n_wr, 1);
    chk("a1_busy", busy, 1'b1);
    cyc(8'h00, 1'b0, 1'b1, 1'b1);

    // bad select
    clr_stats();
    send(SYNC); send(8'h02); idle_cyc();
    chk("badsel_err", n_err, 1);
    chk("badsel_writes", n_wr, 0);
    // SYNC as select is also bad
    clr_stats();
    send(SYNC); send(SYNC); idle_cyc();
    chk("syncsel_err", n_err, 1);

    // toggled in_valid full load, random pixels (SYNC in data is just a pixel)
    clr_stats();
    send(SYNC); send(8'h01);
    for (int i = 0; i < NPIX; i++) begin
      send((i == 5) ? SYNC : 8'($urandom));
      idle_cyc();
    end
    idle_cyc();
    chk("gap_writes", n_wr, NPIX);
    chk("gap_done", n_done, 1);
    chk("gap_last", last_addr, 14'h2FFD);

    // abort on 500th pixel
    clr_stats();
    send(SYNC); send(8'h00);
    for (int i = 0; i < 499; i++) send(8'($urandom));
    cyc(8'h05, 1'b1, 1'b1, 1'b1);
    idle_cyc();
    chk("abort_writes", n_wr, 499);
    chk("abort_done", n_done, 0);
    clr_stats();
    send(SYNC); send(8'h00); send(8'h03);
    chk("abort_restart", first_addr, 14'h0000);

    // reset mid-load at pixel 1000
    for (int i = 1; i < 1000; i++) send(8'($urandom));
    clr_stats();
    cyc(8'h04, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) send(8'($urandom_range(0, 7)));
    chk("rst_writes", n_wr, 0);

    // random mix of sync/select/pixel/abort/gaps
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] b;
      case ($urandom_range(0, 5))
        0: b = SYNC;
        1: b = 8'h00;
        2: b = 8'h01;
        3: b = 8'h02;
        default: b = 8'($urandom);
      endcase
      cyc(b, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 60) == 0), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sprite_loader.md
SPRITE_LOADER -- requirements
Module: sprite_loader

Interface
REQ-001 SHALL have parameter COLS, default 126, meaning pixels per atlas row (3 sprites x 42).
REQ-002 SHALL have parameter ROWS, default 96, meaning atlas rows (2 sprites x 48).
REQ-003 SHALL have parameter SYNC, default 8'hA5, meaning load-start marker byte.
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port in_data  input  8  byte stream from host.
REQ-007 SHALL have port in_valid  input  1  in_data valid.
REQ-008 SHALL have port in_ready  output  1  loader accepts byte this cycle.
REQ-009 SHALL have port abort  input  1  synchronous load cancel.
REQ-010 SHALL have port wr_en  output  1  VRAM write strobe.
REQ-011 SHALL have port wr_addr  output  14  VRAM address {row[6:0], col[6:0]}.
REQ-012 SHALL have port wr_data  output  3  RGB pixel, in_data[2:0].
REQ-013 SHALL have port wr_select  output  1  block-RAM set: 0 = atlas 0 (sprites 0-5), 1 = atlas 1 (sprites 6-7).
REQ-014 SHALL have port busy  output  1  high in SEL or LOAD.
REQ-015 SHALL have port done  output  1  one-cycle pulse: atlas fully written.
REQ-016 SHALL have port err  output  1  one-cycle pulse: bad select byte.

Function
REQ-017 SHALL accept a byte only on a cycle where in_valid and in_ready are both high (transfer).
REQ-018 SHALL implement FSM states IDLE, SEL, LOAD, DONE.
REQ-019 IDLE: in_ready=1; transfer of SYNC -> SEL; any other byte dropped, no write, stay IDLE.
REQ-020 SEL: in_ready=1; transfer of 8'h00 or 8'h01 latches wr_select=in_data[0], clears row/col to 0 -> LOAD; any other value -> err pulse next cycle, -> IDLE, wr_select unchanged.
REQ-021 LOAD: in_ready=1; each transfer produces exactly one write on the next cycle: wr_en=1, wr_addr={row,col} of that pixel, wr_data=in_data[2:0]; in_data[7:3] ignored.
REQ-022 Addressing: col increments per transfer; col=COLS-1 wraps to 0 and row increments; row/col stay in 0..ROWS-1 / 0..COLS-1; addresses for cols COLS..127 and rows ROWS..127 never written.
REQ-023 Transfer at row=ROWS-1, col=COLS-1 -> DONE; that pixel's write occurs in the same cycle DONE is entered.
REQ-024 DONE: in_ready=0, done=1 for exactly one cycle, -> IDLE next cycle.
REQ-025 Write latency SHALL be exactly 1 cycle from transfer; wr_en low on every cycle not following a LOAD transfer; wr_addr/wr_data hold last values when wr_en low.
REQ-026 Idle in_valid gaps in LOAD SHALL stall the counters without error; no timeout.
REQ-027 abort high: next state IDLE from any state, byte presented that cycle not accepted for write (no wr_en next cycle), no done/err pulse; row/col cleared; abort has priority over all transitions.
REQ-028 SYNC value received in SEL is a bad select (err); SYNC value in LOAD is ordinary pixel data.
REQ-029 busy SHALL be registered state decode: 1 in SEL and LOAD, 0 in IDLE and DONE.

Reset
REQ-030 reset=0 at a rising edge SHALL force IDLE, row=col=0, wr_en=0, wr_addr=0, wr_data=0, wr_select=0, done=0, err=0, busy=0; in_ready=1 on the first cycle after reset release.
REQ-031 Reset mid-LOAD SHALL discard progress; no write issued on the cycle after the reset edge.

Verification
REQ-032 Bytes A5,00 then 12096 pixels with data=index mod 8 -> 12096 writes, first addr 14'h0000, addr after col 125 row 0 is 14'h0080, last 14'h2FFD, done pulse once, wr_select=0.
REQ-033 Bytes 3C,A5,01,07 -> 3C dropped; single write addr 0, data 3'b111, wr_select=1, busy=1.
REQ-034 Bytes A5,02 -> err pulse one cycle after 02 transfer, no writes, state IDLE, busy=0.
REQ-035 Load with in_valid toggling every other cycle -> writes only after transfers, addresses contiguous, total 12096, done once.
REQ-036 abort asserted with 500th pixel presented -> 499 writes only, IDLE next cycle, no done; following A5,00,pixel writes addr 0.
REQ-037 reset=0 during LOAD at pixel 1000 -> all outputs to reset values next cycle, no further writes until new SYNC sequence.
